// File: rtl/core_dmem_resp.sv
// ---------------------------------------------------------------------------
// core_dmem_resp
//   Data-side memory responder. It is the slave end of the core's data
//   request interface. It accepts one load or store at a time and serves it
//   from an internal word-organised SRAM after a fixed latency.
//
// Parameters
//   DEPTH      memory size in 32-bit words (power of two, >= 4)
//   LATENCY    cycles from the accept cycle to the ack cycle (1..15)
//   BASE_ADDR  byte address of word 0 (DEPTH*4 aligned)
//
// Ports
//   core_sys_clk  in   clock, rising edge
//   core_sys_rst  in   asynchronous active-high reset
//   d_req_val     in   request valid; held with all fields until ack
//   d_req_addr    in   byte address
//   d_req_cop     in   3'b000 read, 3'b001 write
//   d_req_wdata   in   right-justified store data
//   d_req_size    in   3'b000 byte, 3'b001 half, 3'b010 word
//   d_req_ack     out  one-cycle completion pulse
//   d_ack_rdata   out  zero-extended load data, 0 outside the ack cycle
//   d_ack_err     out  illegal-request flag in the ack cycle
//                      (port exists only when DMEM_ERR_EN is defined)
//
// Optional feature macro: DMEM_ERR_EN
// ---------------------------------------------------------------------------
module core_dmem_resp #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        core_sys_clk,
    input  logic        core_sys_rst,
    input  logic        d_req_val,
    input  logic [31:0] d_req_addr,
    input  logic [2:0]  d_req_cop,
    input  logic [31:0] d_req_wdata,
    input  logic [2:0]  d_req_size,
    output logic        d_req_ack,
    output logic [31:0] d_ack_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic        d_ack_err
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);

    localparam logic [2:0] COP_RD  = 3'b000;
    localparam logic [2:0] COP_WR  = 3'b001;
    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [3:0]      cnt;

    // Request fields latched in the accept cycle
    logic [AW-1:0]   idx_q;
    logic [1:0]      lane_q;
    logic [2:0]      size_q;
    logic            rd_ok_q;   // legal read
    logic [3:0]      be_q;      // all-zero unless legal write
    logic [31:0]     wrep_q;    // store data replicated into its lanes
`ifdef DMEM_ERR_EN
    logic            legal_q;
`endif

    logic [31:0]     mem [DEPTH];

    // ------------------------------------------------------------------
    // Classification of the request presented on the inputs
    // ------------------------------------------------------------------
    logic [31:0] offset_in;
    logic        legal_in;
    logic        write_in;
    logic [3:0]  be_in;
    logic [31:0] wrep_in;

    // Unsigned subtraction: addresses below BASE_ADDR wrap high and fail
    // the range check.
    assign offset_in = d_req_addr - BASE_ADDR;
    assign write_in  = (d_req_cop == COP_WR);

    // NOTE: every variable written in an always_comb gets a default first;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        legal_in = 1'b1;
        if (d_req_cop != COP_RD && d_req_cop != COP_WR)        legal_in = 1'b0;
        if (d_req_size > SZ_WORD)                              legal_in = 1'b0;
        if (d_req_size == SZ_HALF && d_req_addr[0])            legal_in = 1'b0;
        if (d_req_size == SZ_WORD && d_req_addr[1:0] != 2'b00) legal_in = 1'b0;
        if (offset_in >= SPAN)                                 legal_in = 1'b0;
    end

    always_comb begin
        be_in   = 4'b0000;
        wrep_in = d_req_wdata;
        case (d_req_size)
            SZ_BYTE: begin
                be_in   = 4'b0001 << d_req_addr[1:0];
                wrep_in = {4{d_req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_in   = d_req_addr[1] ? 4'b1100 : 4'b0011;
                wrep_in = {2{d_req_wdata[15:0]}};
            end
            SZ_WORD: be_in = 4'b1111;
            default: be_in = 4'b0000;
        endcase
        // Illegal requests and reads must never touch the array.
        if (!(legal_in && write_in)) be_in = 4'b0000;
    end

    // ------------------------------------------------------------------
    // Read path. With LATENCY=1 the registered outputs are loaded at the
    // accept edge itself, so the live request fields are used in IDLE and
    // the latched ones in BUSY.
    // ------------------------------------------------------------------
    logic          busy;
    logic          accept;
    logic          ack_next;
    logic [AW-1:0] sel_idx;
    logic [1:0]    sel_lane;
    logic [2:0]    sel_size;
    logic          sel_rd_ok;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_data;

    assign busy      = (state == BUSY);
    assign accept    = (state == IDLE) && d_req_val;
    assign ack_next  = (accept && CNT_INIT == 4'd0) || (busy && cnt == 4'd1);

    assign sel_idx   = busy ? idx_q   : offset_in[AW+1:2];
    assign sel_lane  = busy ? lane_q  : d_req_addr[1:0];
    assign sel_size  = busy ? size_q  : d_req_size;
    assign sel_rd_ok = busy ? rd_ok_q : (legal_in && !write_in);

    assign rd_shift  = mem[sel_idx] >> {sel_lane, 3'b000};

    always_comb begin
        rd_data = 32'h0;
        case (sel_size)
            SZ_BYTE: rd_data = {24'h0, rd_shift[7:0]};
            SZ_HALF: rd_data = {16'h0, rd_shift[15:0]};
            SZ_WORD: rd_data = rd_shift;
            default: rd_data = 32'h0;
        endcase
    end

`ifdef DMEM_ERR_EN
    logic sel_legal;
    assign sel_legal = busy ? legal_q : legal_in;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge core_sys_clk or posedge core_sys_rst) begin
        if (core_sys_rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            d_req_ack   <= 1'b0;
            d_ack_rdata <= 32'h0;
            idx_q       <= '0;
            lane_q      <= 2'b00;
            size_q      <= 3'b000;
            rd_ok_q     <= 1'b0;
            be_q        <= 4'b0000;
            wrep_q      <= 32'h0;
`ifdef DMEM_ERR_EN
            d_ack_err   <= 1'b0;
            legal_q     <= 1'b0;
`endif
        end else begin
            d_req_ack   <= ack_next;
            d_ack_rdata <= (ack_next && sel_rd_ok) ? rd_data : 32'h0;
`ifdef DMEM_ERR_EN
            d_ack_err   <= ack_next && !sel_legal;
`endif
            case (state)
                IDLE: begin
                    if (d_req_val) begin
                        state   <= BUSY;
                        cnt     <= CNT_INIT;
                        idx_q   <= offset_in[AW+1:2];
                        lane_q  <= d_req_addr[1:0];
                        size_q  <= d_req_size;
                        rd_ok_q <= legal_in && !write_in;
                        be_q    <= be_in;
                        wrep_q  <= wrep_in;
`ifdef DMEM_ERR_EN
                        legal_q <= legal_in;
`endif
                    end
                end
                BUSY: begin
                    // cnt == 0 is the ack cycle; leave on its closing edge.
                    if (cnt == 4'd0) state <= IDLE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage. Writes commit at the closing edge of the ack cycle; a reset
    // during BUSY returns the FSM to IDLE, so the pending write is dropped.
    // ------------------------------------------------------------------
    // NOTE: the array is deliberately not reset; clearing an SRAM needs a
    // port per word and its contents are undefined until written anyway.
    always_ff @(posedge core_sys_clk) begin
        if (busy && cnt == 4'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= wrep_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_core_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_core_dmem_resp
//   Four responder instances (LATENCY 2, 1, 3, 15) each driven by its own
//   request bus. A byte-addressed reference memory predicts every ack cycle,
//   rdata and error flag; one compare process checks all instances on every
//   falling edge. Directed literals pin the model on the key cases.
// ---------------------------------------------------------------------------
module tb_core_dmem_resp;

    localparam int N     = 4;
    localparam int DEPTH = 1024;

    localparam logic [2:0] RD = 3'b000, WR = 3'b001;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [N];
    logic        val   [N];
    logic [31:0] addr  [N];
    logic [2:0]  cop   [N];
    logic [31:0] wdata [N];
    logic [2:0]  size  [N];
    logic        ack   [N];
    logic [31:0] rdata [N];
    logic        err   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        core_dmem_resp #(
            .DEPTH     (DEPTH),
            .LATENCY   (lat_of(g)),
            .BASE_ADDR (32'h0000_0000)
        ) u_dut (
            .core_sys_clk (clk),
            .core_sys_rst (rst[g]),
            .d_req_val    (val[g]),
            .d_req_addr   (addr[g]),
            .d_req_cop    (cop[g]),
            .d_req_wdata  (wdata[g]),
            .d_req_size   (size[g]),
            .d_req_ack    (ack[g]),
            .d_ack_rdata  (rdata[g])
`ifdef DMEM_ERR_EN
            ,
            .d_ack_err    (err[g])
`endif
        );
`ifndef DMEM_ERR_EN
        assign err[g] = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] cycle %0d: got %h, expected %h",
                      name, k, cyc, act, exp);
    endtask

    // Reference memory, byte addressed (BASE_ADDR is 0)
    logic [7:0]  mm [N][DEPTH*4];

    // One outstanding expectation per instance
    bit          exp_valid [N];
    int          exp_cyc   [N];
    logic [31:0] exp_rdata [N];
    bit          exp_err   [N];
    logic [31:0] last_rdata [N];
    logic        last_err   [N];
    int          ack_log [$];

    function automatic bit model_legal(input logic [2:0] c, input logic [2:0] s,
                                       input logic [31:0] a);
        int unsigned nbytes;
        if (c != RD && c != WR) return 1'b0;
        if (s > SW)             return 1'b0;
        nbytes = 1 << s;
        if (a % nbytes != 0)    return 1'b0;
        if (a >= DEPTH * 4)     return 1'b0;
        return 1'b1;
    endfunction

    // Compare process: every cycle, every instance
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            bit want;
            want = exp_valid[k] && (cyc == exp_cyc[k]);
            check("ack", k, 32'(ack[k]), 32'(want));
            check("rdata", k, rdata[k], want ? exp_rdata[k] : 32'h0);
`ifdef DMEM_ERR_EN
            check("err", k, 32'(err[k]), 32'(want && exp_err[k]));
`endif
            if (ack[k] === 1'b1) begin
                last_rdata[k] = rdata[k];
                last_err[k]   = err[k];
                if (k == 1) ack_log.push_back(cyc);
            end
            if (exp_valid[k] && cyc >= exp_cyc[k]) exp_valid[k] = 1'b0;
        end
    end

    // Issue one request on instance k (call at a falling edge). Returns at
    // the falling edge of the cycle after the ack, with val still high so
    // the next call continues back-to-back. abort asserts reset one cycle
    // after the accept and abandons the request.
    task automatic req(input int k, input logic [2:0] c, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit abort = 1'b0);
        int          lat;
        int          nb;
        bit          lg;
        logic [31:0] e;
        lat = lat_of(k);
        val[k] = 1'b1; cop[k] = c; size[k] = s; addr[k] = a; wdata[k] = d;
        lg = model_legal(c, s, a);
        nb = 1 << s;
        e  = 32'h0;
        if (lg && c == RD)
            for (int i = 0; i < nb; i++) e |= 32'(mm[k][a + i]) << (8 * i);
        exp_rdata[k] = e;
        exp_err[k]   = !lg;
        exp_cyc[k]   = cyc + lat;
        exp_valid[k] = 1'b1;
        if (abort) begin
            @(negedge clk);
            rst[k] = 1'b1;
            val[k] = 1'b0;
            exp_valid[k] = 1'b0;
            #1;
            check("rst_ack", k, 32'(ack[k]), 32'h0);
            check("rst_rdata", k, rdata[k], 32'h0);
            check("rst_err", k, 32'(err[k]), 32'h0);
            repeat (3) @(negedge clk);
            rst[k] = 1'b0;
        end else begin
            if (lg && c == WR)
                for (int i = 0; i < nb; i++) mm[k][a + i] = d[8*i +: 8];
            repeat (lat + 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int k);
        val[k] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int base;
        logic [2:0]  c, s;
        logic [1:0]  lane;
        logic [31:0] a;

        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; val[k] = 1'b0; addr[k] = 32'h0;
            cop[k] = RD; wdata[k] = 32'h0; size[k] = SW;
            exp_valid[k] = 1'b0; last_rdata[k] = 32'h0; last_err[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("reset_ack", k, 32'(ack[k]), 32'h0);
            check("reset_rdata", k, rdata[k], 32'h0);
            check("reset_err", k, 32'(err[k]), 32'h0);
            rst[k] = 1'b0;
        end
        @(negedge clk);

        // Word store/load, byte/half merge (LATENCY=2)
        req(0, WR, SW, 32'h10, 32'hDEAD_BEEF);
        check("wr_rdata", 0, last_rdata[0], 32'h0);
        req(0, RD, SW, 32'h10, 32'h0);
        check("rd_word", 0, last_rdata[0], 32'hDEAD_BEEF);
        req(0, WR, SB, 32'h11, 32'h0000_0055);
        req(0, WR, SH, 32'h12, 32'h0000_A5A5);
        req(0, RD, SW, 32'h10, 32'h0);
        check("merge_word", 0, last_rdata[0], 32'hA5A5_55EF);
        req(0, RD, SB, 32'h13, 32'h0);
        check("merge_byte", 0, last_rdata[0], 32'h0000_00A5);
        req(0, RD, SH, 32'h12, 32'h0);
        check("merge_half", 0, last_rdata[0], 32'h0000_A5A5);

        // Illegal accesses
        req(0, WR, SW, 32'h0, 32'h0102_0304);
        req(0, RD, SH, 32'h11, 32'h0);
        check("misaligned_rdata", 0, last_rdata[0], 32'h0);
`ifdef DMEM_ERR_EN
        check("misaligned_err", 0, 32'(last_err[0]), 32'h1);
`endif
        req(0, WR, SW, 32'(DEPTH * 4), 32'hFFFF_FFFF);
        req(0, RD, SW, 32'h0, 32'h0);
        check("range_no_write", 0, last_rdata[0], 32'h0102_0304);
        req(0, 3'b111, SW, 32'h10, 32'hFFFF_FFFF);
        check("bad_cop_rdata", 0, last_rdata[0], 32'h0);
        req(0, WR, 3'b011, 32'h10, 32'hFFFF_FFFF);
        req(0, RD, SW, 32'hFFFF_FFFC, 32'h0);
        req(0, RD, SW, 32'h10, 32'h0);
        check("illegal_no_write", 0, last_rdata[0], 32'hA5A5_55EF);
        idle(0);

        // Back-to-back with val held high (LATENCY=1)
        ack_log.delete();
        base = cyc;
        req(1, WR, SW, 32'h40, 32'h1111_1111);
        req(1, WR, SW, 32'h44, 32'h2222_2222);
        req(1, RD, SW, 32'h40, 32'h0);
        idle(1);
        check("b2b_rdata", 1, last_rdata[1], 32'h1111_1111);
        check("b2b_ack_count", 1, 32'(ack_log.size()), 32'd3);
        if (ack_log.size() == 3) begin
            check("b2b_ack0", 1, 32'(ack_log[0] - base), 32'd1);
            check("b2b_ack1", 1, 32'(ack_log[1] - base), 32'd3);
            check("b2b_ack2", 1, 32'(ack_log[2] - base), 32'd5);
        end

        // Reset mid-request (LATENCY=3)
        req(2, WR, SW, 32'h20, 32'hCAFE_F00D);
        req(2, WR, SW, 32'h20, 32'h1234_5678, 1'b1);
        req(2, RD, SW, 32'h20, 32'h0);
        check("rst_dropped_write", 2, last_rdata[2], 32'hCAFE_F00D);
        idle(2);

        // LATENCY=15 sweep over a 16-word window
        for (int w = 0; w < 16; w++) req(3, WR, SW, 32'(w * 4), $urandom);
        for (int n = 0; n < 100; n++) begin
            c = ($urandom_range(0, 1) == 0) ? RD : WR;
            s = 3'($urandom_range(0, 2));
            lane = 2'($urandom_range(0, 3));
            if (s == SH) lane[0] = 1'b0;
            if (s == SW) lane = 2'b00;
            a = 32'($urandom_range(0, 15) * 4) | {30'h0, lane};
            req(3, c, s, a, $urandom);
        end
        idle(3);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/core_dmem_resp.md
# core_dmem_resp

Data-side memory responder: the slave end of the core's data request interface (`d_req_*` / `d_ack_*`). It accepts one load or store at a time from the core pipeline and serves it from an internal word-organised SRAM after a fixed, parameterised latency. It sits in the core testbench and in small SoC builds in place of the L1D/bus path.

## Interface
- DEPTH, 1024: memory size in 32-bit words; power of two, ≥4.
- LATENCY, 2: cycles from the accept cycle to the ack cycle; allowed range 1..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.
- core_sys_clk  in  1  clock; all logic on the rising edge.
- core_sys_rst  in  1  asynchronous, active-high reset.
- d_req_val  in  1  request valid; the requester holds it and all request fields stable until ack.
- d_req_addr  in  32  byte address.
- d_req_cop  in  3  operation: 3'b000 read, 3'b001 write; all other values are illegal.
- d_req_wdata  in  32  store data, right-justified: byte in [7:0], half in [15:0].
- d_req_size  in  3  access size: 3'b000 byte, 3'b001 half, 3'b010 word; all other values are illegal.
- d_req_ack  out  1  one-cycle completion pulse.
- d_ack_rdata  out  32  load data, valid only while d_req_ack=1; 0 in all other cycles.
- d_ack_err  out  1  present only with DMEM_ERR_EN; qualified by d_req_ack.

## Operation
- FSM states: IDLE and BUSY.
- IDLE → BUSY when d_req_val=1. This is the accept cycle T. On acceptance the block latches addr, cop, wdata and size, and loads the down-counter with LATENCY-1.
- In BUSY the counter decrements each cycle while it is non-zero.
  - When the counter is 0, d_req_ack=1 for exactly one cycle. This is cycle T+LATENCY.
  - The FSM returns to IDLE on the next edge.
- Requests are never accepted in BUSY, including the ack cycle. The earliest next accept is T+LATENCY+1, so peak throughput is one request per LATENCY+1 cycles.
- Each request is classified in the accept cycle. It is illegal if any of these holds:
  - cop is illegal;
  - size is illegal;
  - a half access has addr[0]≠0;
  - a word access has addr[1:0]≠0;
  - addr-BASE_ADDR ≥ DEPTH*4, computed as a 32-bit unsigned subtraction, so addresses below BASE_ADDR wrap high and fail.
- Word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2]. Lane = addr[1:0].
- Legal read: the selected byte, half or word is shifted down to bit 0 and zero-extended onto d_ack_rdata. Sign extension is done by the core.
- Legal write:
  - Byte-enables are derived from size and lane. wdata is replicated into the selected lanes.
  - Only the enabled bytes are updated. The update commits at the ack-cycle edge.
  - d_ack_rdata=0 for writes.
- Illegal request: it is still acked at T+LATENCY with d_ack_rdata=0 and no memory update.
- If d_req_val drops before ack, that is a protocol violation. The block completes the latched request and pulses ack regardless.
- Memory contents are not reset; they are X until written.

## Timing
- Reset values: FSM=IDLE, counter=0, d_req_ack=0, d_ack_rdata=0, d_ack_err=0.
- Reset asserted mid-request (BUSY): the request is abandoned, no ack is issued, and a pending write is dropped.
- Load latency: LATENCY cycles from accept to the ack/rdata cycle. d_ack_rdata is registered.
- Store visibility: a read accepted at T+LATENCY+1 after a write to the same word returns the new data.
- LATENCY=1: ack is asserted the cycle after accept, and the BUSY state lasts one cycle.

## Configuration
- DMEM_ERR_EN defined:
  - Port d_ack_err exists.
  - It equals 1 in the ack cycle of an illegal request and is 0 otherwise.
- DMEM_ERR_EN undefined:
  - The port is absent and no error logic is built.
  - Illegal requests are still acked silently with rdata 0 and no write.

## Test plan
- Word store/load, LATENCY=2, BASE_ADDR=0:
  - write 0xDEADBEEF to 0x10 → ack at T+2, rdata 0;
  - read 0x10 → ack at T+2, rdata 0xDEADBEEF.
- Byte/half merge:
  - after the above, byte write 0x55 to 0x11 and half write 0xA5A5 to 0x12;
  - word read 0x10 returns 0xA5A555EF;
  - byte read 0x13 returns 0x000000A5.
- Illegal accesses:
  - half read at 0x11 → ack with rdata 0, d_ack_err=1 when DMEM_ERR_EN is defined;
  - word write at DEPTH*4 → ack, no write; a subsequent read of 0x0 is unchanged;
  - cop=3'b111 → ack with rdata 0, memory unchanged.
- Back-to-back with val held high continuously, LATENCY=1 → accepts at cycles 0, 2 and 4, acks at 1, 3 and 5, and no request is accepted in an ack cycle.
- Reset mid-request: assert core_sys_rst one cycle after accepting a write of 0x12345678 to 0x20 (LATENCY=3) → no ack is issued, all outputs read 0 during reset, and 0x20 is not written.
- LATENCY=15 sweep of 100 random legal read/write requests against a reference model → every ack arrives exactly 15 cycles after its accept and all read data matches the model.
